chip8_call_stack: RTL and testbench

Parametrised subroutine-return stack for the Chip-8 CPU core, successor to the fixed 16×16 push/pop stack. It holds return addresses for CALL (2NNN) and RET (00EE) and adds a combined pop-then-push operation, occupancy and full/empty status, and sticky overflow/underflow error flags. It sits beside the program-counter logic in the CPU datapath and is clocked by the CPU clock.

---
 rtl/chip8_call_stack.sv | 135 +++++++++++++
 tb/tb_chip8_call_stack.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_call_stack.sv
// chip8_call_stack: parametrised return-address stack for the Chip-8 core.
// Supports push, pop and a same-cycle replace (pop then push). It reports
// occupancy and full/empty status, and keeps sticky overflow/underflow flags.
// The storage array is deliberately left unreset; only the control state is reset.
module chip8_call_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             cpu_clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] writedata,
  input  logic             clear_err,
  output logic [WIDTH-1:0] outdata,
  output logic             pop_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = CW - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] outdata_q, outdata_d;
  logic             pop_valid_q, pop_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             empty_s;
  logic             full_s;
  logic [AW-1:0]    top_idx_s;
  logic             wr_en_s;
  logic [AW-1:0]    wr_idx_s;
  logic [WIDTH-1:0] wr_data_s;

  // Status is derived from the occupancy counter. The top index wraps to
  // DEPTH-1 when the stack is full, because DEPTH is a power of two.
  assign empty_s   = (count_q == {CW{1'b0}});
  assign full_s    = (count_q == DEPTH_C);
  assign top_idx_s = count_q[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};

  // Next-state logic: decode the operation into counter, output, flag and write updates.
  always_comb begin
    count_d     = count_q;
    outdata_d   = outdata_q;
    pop_valid_d = 1'b0;
    overflow_d  = clear_err ? 1'b0 : overflow_q;
    underflow_d = clear_err ? 1'b0 : underflow_q;
    wr_en_s     = 1'b0;
    wr_idx_s    = top_idx_s;
    wr_data_s   = writedata;
    case (op)
      OP_PUSH: begin
        if (full_s) begin
          overflow_d = 1'b1;
        end else begin
          wr_en_s  = 1'b1;
          wr_idx_s = count_q[AW-1:0];
          count_d  = count_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      OP_POP: begin
        if (empty_s) begin
          underflow_d = 1'b1;
        end else begin
          outdata_d   = mem_q[top_idx_s];
          count_d     = count_q - {{(CW-1){1'b0}}, 1'b1};
          pop_valid_d = 1'b1;
        end
      end
      OP_REPL: begin
        if (empty_s) begin
          underflow_d = 1'b1;
        end else begin
          outdata_d   = mem_q[top_idx_s];
          wr_en_s     = 1'b1;
          wr_idx_s    = top_idx_s;
          pop_valid_d = 1'b1;
        end
      end
      OP_NOP: begin
        pop_valid_d = 1'b0;
      end
      default: begin
        pop_valid_d = 1'b0;
      end
    endcase
  end

  // Control state register with asynchronous reset; any reset discards all entries.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      count_q     <= {CW{1'b0}};
      outdata_q   <= {WIDTH{1'b0}};
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      outdata_q   <= outdata_d;
      pop_valid_q <= pop_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array write port. The array has no reset; entries are undefined until pushed.
  always_ff @(posedge cpu_clk) begin
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= wr_data_s;
    end
  end

  assign outdata   = outdata_q;
  assign pop_valid = pop_valid_q;
  assign count     = count_q;
  assign empty     = empty_s;
  assign full      = full_s;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign top       = empty_s ? {WIDTH{1'b0}} : mem_q[top_idx_s];

endmodule

// File: tb/tb_chip8_call_stack.sv
// Scoreboard bench for chip8_call_stack. It instantiates a 16x16 DUT (a) and a 12-bit x 4 DUT (b).
// The stimulus pushes the expected pop values into per-DUT queues.
// The monitors pop those queues and compare whenever a DUT pulses pop_valid.
module tb_chip8_call_stack;

  logic        clk;
  logic        rst;

  logic [1:0]  op_a;
  logic [15:0] wd_a;
  logic        ce_a;
  logic [15:0] out_a, top_a;
  logic        pv_a, empty_a, full_a, ovf_a, unf_a;
  logic [4:0]  cnt_a;

  logic [1:0]  op_b;
  logic [11:0] wd_b;
  logic        ce_b;
  logic [11:0] out_b, top_b;
  logic        pv_b, empty_b, full_b, ovf_b, unf_b;
  logic [2:0]  cnt_b;

  int n_cmp;
  int n_err;

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];

  chip8_call_stack #(.WIDTH(16), .DEPTH(16)) dut_a (
    .cpu_clk(clk), .reset(rst), .op(op_a), .writedata(wd_a), .clear_err(ce_a),
    .outdata(out_a), .pop_valid(pv_a), .top(top_a), .count(cnt_a),
    .empty(empty_a), .full(full_a), .overflow(ovf_a), .underflow(unf_a)
  );

  chip8_call_stack #(.WIDTH(12), .DEPTH(4)) dut_b (
    .cpu_clk(clk), .reset(rst), .op(op_b), .writedata(wd_b), .clear_err(ce_b),
    .outdata(out_b), .pop_valid(pv_b), .top(top_b), .count(cnt_b),
    .empty(empty_b), .full(full_b), .overflow(ovf_b), .underflow(unf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor for DUT a: each pop_valid pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (pv_a === 1'b1) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_unexpected_pop: actual=%h required=no pulse", out_a);
      end else begin
        check("a_pop_data", {16'h0, out_a}, {16'h0, q_a.pop_front()});
      end
    end
  end

  // Monitor for DUT b.
  always @(negedge clk) begin
    if (pv_b === 1'b1) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_unexpected_pop: actual=%h required=no pulse", out_b);
      end else begin
        check("b_pop_data", {20'h0, out_b}, {16'h0, q_b.pop_front()});
      end
    end
  end

  // One cycle of stimulus on the selected DUT. The task returns 1 ns after the edge.
  task automatic step(input int sel, input logic [1:0] o, input logic [15:0] d, input logic ce);
    if (sel == 0) begin
      op_a = o; wd_a = d; ce_a = ce;
    end else begin
      op_b = o; wd_b = d[11:0]; ce_b = ce;
    end
    @(posedge clk);
    #1;
    op_a = 2'b00; op_b = 2'b00; ce_a = 1'b0; ce_b = 1'b0;
  endtask

  task automatic push(input int sel, input logic [15:0] d);
    step(sel, 2'b01, d, 1'b0);
  endtask

  task automatic pop_exp(input int sel, input logic [15:0] exp);
    if (sel == 0) q_a.push_back(exp); else q_b.push_back(exp);
    step(sel, 2'b10, 16'h0, 1'b0);
  endtask

  task automatic repl_exp(input int sel, input logic [15:0] d, input logic [15:0] exp);
    if (sel == 0) q_a.push_back(exp); else q_b.push_back(exp);
    step(sel, 2'b11, d, 1'b0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    op_a = 2'b00; wd_a = 16'h0; ce_a = 1'b0;
    op_b = 2'b00; wd_b = 12'h0; ce_b = 1'b0;
    #7;
    check("rst_count", {27'h0, cnt_a}, 32'd0);
    check("rst_empty", {31'h0, empty_a}, 32'd1);
    check("rst_full", {31'h0, full_a}, 32'd0);
    check("rst_top", {16'h0, top_a}, 32'h0);
    check("rst_outdata", {16'h0, out_a}, 32'h0);
    check("rst_flags", {30'h0, ovf_a, unf_a}, 32'd0);
    check("rst_pop_valid", {31'h0, pv_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic push/pop ordering.
    push(0, 16'h0200); push(0, 16'h0202); push(0, 16'h0204);
    check("s1_count3", {27'h0, cnt_a}, 32'd3);
    check("s1_top", {16'h0, top_a}, 32'h0204);
    pop_exp(0, 16'h0204); pop_exp(0, 16'h0202); pop_exp(0, 16'h0200);
    check("s1_empty", {31'h0, empty_a}, 32'd1);
    check("s1_top_empty", {16'h0, top_a}, 32'h0);
    check("s1_count0", {27'h0, cnt_a}, 32'd0);
    step(0, 2'b00, 16'h0, 1'b0);
    check("s1_pv_low", {31'h0, pv_a}, 32'd0);

    // Fill to DEPTH, overflow, then drain in LIFO order.
    for (int i = 0; i < 16; i++) begin
      v = 16'h1100 + 16'(i) * 16'h0101;
      push(0, v);
    end
    check("s2_full", {31'h0, full_a}, 32'd1);
    check("s2_count16", {27'h0, cnt_a}, 32'd16);
    check("s2_top", {16'h0, top_a}, 32'h200F);
    push(0, 16'hFFFF);
    check("s2_overflow", {31'h0, ovf_a}, 32'd1);
    check("s2_count_hold", {27'h0, cnt_a}, 32'd16);
    check("s2_top_hold", {16'h0, top_a}, 32'h200F);
    for (int i = 15; i >= 0; i--) begin
      v = 16'h1100 + 16'(i) * 16'h0101;
      pop_exp(0, v);
    end
    check("s2_empty", {31'h0, empty_a}, 32'd1);

    // Underflow and clear_err behaviour.
    step(0, 2'b10, 16'h0, 1'b0);
    check("s3_underflow", {31'h0, unf_a}, 32'd1);
    check("s3_pv", {31'h0, pv_a}, 32'd0);
    check("s3_outdata_hold", {16'h0, out_a}, 32'h1100);
    check("s3_count", {27'h0, cnt_a}, 32'd0);
    step(0, 2'b00, 16'h0, 1'b1);
    check("s3_clr_unf", {31'h0, unf_a}, 32'd0);
    check("s3_clr_ovf", {31'h0, ovf_a}, 32'd0);
    step(0, 2'b10, 16'h0, 1'b1);
    check("s3_set_wins", {31'h0, unf_a}, 32'd1);
    step(0, 2'b00, 16'h0, 1'b1);

    // Replace with one entry, then replace while full.
    push(0, 16'h0300);
    repl_exp(0, 16'h0400, 16'h0300);
    check("s4_pv", {31'h0, pv_a}, 32'd1);
    check("s4_outdata", {16'h0, out_a}, 32'h0300);
    check("s4_count", {27'h0, cnt_a}, 32'd1);
    check("s4_top", {16'h0, top_a}, 32'h0400);
    for (int i = 0; i < 15; i++) push(0, 16'h3000 + 16'(i));
    repl_exp(0, 16'hBEEF, 16'h300E);
    check("s4_full_count", {27'h0, cnt_a}, 32'd16);
    check("s4_full_top", {16'h0, top_a}, 32'hBEEF);
    check("s4_no_ovf", {31'h0, ovf_a}, 32'd0);
    check("s4_full_out", {16'h0, out_a}, 32'h300E);

    // Asynchronous reset mid-sequence with count=5.
    @(negedge clk); #2; rst = 1'b1; #1; rst = 1'b0;
    @(posedge clk); #1;
    step(0, 2'b10, 16'h0, 1'b0);
    for (int i = 0; i < 6; i++) push(0, 16'h0500 + 16'(i));
    pop_exp(0, 16'h0505);
    check("s5_pre_count", {27'h0, cnt_a}, 32'd5);
    check("s5_pre_unf", {31'h0, unf_a}, 32'd1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("s5_async_count", {27'h0, cnt_a}, 32'd0);
    check("s5_async_out", {16'h0, out_a}, 32'h0);
    check("s5_async_flags", {30'h0, ovf_a, unf_a}, 32'd0);
    check("s5_async_empty", {31'h0, empty_a}, 32'd1);
    check("s5_async_top", {16'h0, top_a}, 32'h0);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    push(0, 16'h0ABC);
    check("s5_push_count", {27'h0, cnt_a}, 32'd1);
    check("s5_push_top", {16'h0, top_a}, 32'h0ABC);
    pop_exp(0, 16'h0ABC);

    // Small configuration: WIDTH=12, DEPTH=4.
    push(1, 16'h0200); push(1, 16'h0202); push(1, 16'h0204);
    check("b1_count3", {29'h0, cnt_b}, 32'd3);
    check("b1_top", {20'h0, top_b}, 32'h204);
    pop_exp(1, 16'h0204); pop_exp(1, 16'h0202); pop_exp(1, 16'h0200);
    check("b1_empty", {31'h0, empty_b}, 32'd1);
    check("b1_top_empty", {20'h0, top_b}, 32'h0);
    for (int i = 0; i < 4; i++) push(1, 16'h0A10 + 16'(i));
    check("b2_full", {31'h0, full_b}, 32'd1);
    check("b2_count4", {29'h0, cnt_b}, 32'd4);
    push(1, 16'h0FFF);
    check("b2_overflow", {31'h0, ovf_b}, 32'd1);
    check("b2_count_hold", {29'h0, cnt_b}, 32'd4);
    check("b2_top_hold", {20'h0, top_b}, 32'hA13);
    for (int i = 3; i >= 0; i--) pop_exp(1, 16'h0A10 + 16'(i));
    check("b2_empty", {31'h0, empty_b}, 32'd1);

    @(negedge clk);
    @(negedge clk);
    check("a_queue_drained", q_a.size(), 32'd0);
    check("b_queue_drained", q_b.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
